ft232r_reg_ctrl: RTL and testbench
==================================

Name: ft232r_reg_ctrl

Overview:
- Protocol controller between the FT232R handshake adapter (cmd/rsp byte channels) and an internal 16-bit register bus.
- Receives command frames byte-by-byte over the 4-phase cmd handshake and decodes read/write opcodes.
- Performs one register bus access per frame, then sends the response bytes back over the rsp channel, one byte at a time.

Parameters:
P_CLK_FREQ_HZ, 125_000_000, system clock frequency; documentation only.
P_RX_TIMEOUT, 1_250_000, max idle cycles between bytes inside a frame (10 ms at 125 MHz).
P_BUS_TIMEOUT, 255, max cycles waiting for reg_ack.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cmd_req  in  1  adapter has a received byte
cmd_ack  out  1  4-phase acknowledge to adapter
cmd_data  in  8  received byte
rsp_req  out  1  request adapter to transmit rsp_data; adapter acts on the rising edge
rsp_ack  in  1  1-cycle pulse, byte transmission done
rsp_data  out  8  byte to transmit
reg_addr  out  16  register address
reg_wdata  out  16  write data
reg_we  out  1  1 = write, 0 = read; valid while reg_req is high
reg_req  out  1  bus request, held until reg_ack or timeout
reg_ack  in  1  1-cycle completion pulse
reg_rdata  in  16  read data, valid when reg_ack is high
err_cnt  out  8  saturating count of NAK/timeout events

Behaviour:
- Reset values: cmd_ack=0, rsp_req=0, rsp_data=0, reg_req=0, reg_we=0, reg_addr=0, reg_wdata=0, err_cnt=0, FSM=IDLE. A reset mid-frame discards the frame without emitting a response.
- Cmd receive, 4-phase:
  - When cmd_req=1 and cmd_ack=0, capture cmd_data and set cmd_ack=1 on the next edge.
  - Hold cmd_ack until cmd_req=0 is sampled, then clear it.
  - Each capture produces exactly one internal byte_valid pulse.
  - A new byte is never accepted while cmd_ack=1.
- Frame format (MSB first):
  - Read: 0x52, addr_hi, addr_lo.
  - Write: 0x57, addr_hi, addr_lo, data_hi, data_lo.
- FSM states and transitions:
  - IDLE: wait for a byte. 0x52 or 0x57 latches op and goes to ADDR_H. Any other byte queues NAK (0x15), increments err_cnt, and goes to RSP.
  - ADDR_H -> ADDR_L -> (write: DATA_H -> DATA_L) -> BUS. Each transition occurs on byte_valid.
  - BUS: assert reg_req with reg_addr/reg_wdata/reg_we stable. On reg_ack, drop reg_req the same edge and queue the response:
    - read: {reg_rdata[15:8], reg_rdata[7:0]}
    - write: ACK (0x06)
  - RSP: for each queued byte, drive rsp_data one cycle before raising rsp_req. Hold rsp_req until rsp_ack, then clear rsp_req. Wait ≥1 cycle low (GAP) before the next rsp_req rising edge.
  - After the last byte go to IDLE.
- Bytes arriving during BUS/RSP are still acked and discarded, and err_cnt is incremented. The cmd handshake never stalls the adapter.
- RX timeout:
  - The inter-byte counter resets on every byte_valid and runs only in ADDR_H..DATA_L.
  - Reaching P_RX_TIMEOUT returns the FSM to IDLE silently and increments err_cnt.
- Bus timeout:
  - reg_req held P_BUS_TIMEOUT cycles without reg_ack drops reg_req.
  - Responds NAK and increments err_cnt.
  - A reg_ack arriving in the same cycle as the timeout wins: a normal response is sent.
- err_cnt saturates at 0xFF; it does not wrap.
- Latency: the final request byte's byte_valid leads to reg_req on the next cycle. reg_ack leads to rsp_data valid on the next cycle and rsp_req the cycle after.

Decomposition:
- Package ft232r_reg_pkg:
  - OP_RD=8'h52, OP_WR=8'h57, RSP_ACK=8'h06, RSP_NAK=8'h15
  - FSM state encoding
  - frame length constants
- Sub-module hs4_byte_rx: the 4-phase cmd slave. Outputs byte_valid and byte_data; busy-discard is handled by the parent.
- The rsp byte sequencer is simple enough to stay inline.

Test Plan:
- Read frame 52 12 34, reg_ack on the 3rd cycle of reg_req with reg_rdata=0xBEEF -> reg_addr=0x1234 and reg_we=0 during reg_req; rsp bytes BE then EF, each a separate rsp_req rise.
- Write frame 57 00 10 CA FE, reg_ack immediately -> reg_addr=0x0010, reg_wdata=0xCAFE, reg_we=1; single rsp byte 06; err_cnt=0.
- Bad opcode 0x41 -> single rsp byte 15; err_cnt=1; next valid read frame works normally.
- Send 57 00 then stall longer than P_RX_TIMEOUT (sim override 100) -> no response, err_cnt+1; subsequent 52 00 01 is decoded as a fresh read.
- Read with reg_ack never asserted (P_BUS_TIMEOUT=16) -> reg_req drops after 16 cycles, rsp 15. Repeat with reg_ack in the same cycle as the timeout -> normal 2-byte data response.
- Assert rst during RSP between bytes -> rsp_req=0 and cmd_ack=0 next cycle; no further bytes transmitted; err_cnt=0.

Source files
------------

// File: rtl/ft232r_reg_pkg.sv
// Shared constants and state encoding for the FT232R register-access controller.
package ft232r_reg_pkg;

    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam int unsigned FRAME_LEN_RD = 3;
    localparam int unsigned FRAME_LEN_WR = 5;
    localparam int unsigned RSP_LEN_RD   = 2;
    localparam int unsigned RSP_LEN_WR   = 1;

    typedef enum logic [2:0] {
        StIdle,
        StAddrH,
        StAddrL,
        StDataH,
        StDataL,
        StBus,
        StRspLoad,
        StRspWait
    } state_e;

endpackage

// File: rtl/hs4_byte_rx.sv
// 4-phase handshake slave: captures one byte per cmd_req cycle and pulses byte_valid once.
module hs4_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_req,
    input  logic [7:0] cmd_data,
    output logic       cmd_ack,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic       ack_q, ack_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        ack_d   = ack_q;
        valid_d = 1'b0;
        data_d  = data_q;
        if (!ack_q && cmd_req) begin
            ack_d   = 1'b1;
            valid_d = 1'b1;
            data_d  = cmd_data;
        end else if (ack_q && !cmd_req) begin
            ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign cmd_ack    = ack_q;
    assign byte_valid = valid_q;
    assign byte_data  = data_q;

endmodule

// File: rtl/ft232r_reg_ctrl.sv
// Decodes read/write command frames from the FT232R adapter, performs one 16-bit register
// bus access per frame and returns the response bytes over the rsp handshake.
module ft232r_reg_ctrl
    import ft232r_reg_pkg::*;
#(
    parameter int unsigned P_CLK_FREQ_HZ = 125_000_000,
    parameter int unsigned P_RX_TIMEOUT  = 1_250_000,
    parameter int unsigned P_BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic [7:0]  cmd_data,
    output logic        rsp_req,
    input  logic        rsp_ack,
    output logic [7:0]  rsp_data,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_req,
    input  logic        reg_ack,
    input  logic [15:0] reg_rdata,
    output logic [7:0]  err_cnt
);

    localparam int unsigned RxCntW  = $clog2(P_RX_TIMEOUT + 1);
    localparam int unsigned BusCntW = $clog2(P_BUS_TIMEOUT + 1);

    if (P_CLK_FREQ_HZ == 0) begin : g_bad_clk_freq
        $error("P_CLK_FREQ_HZ must be non-zero");
    end

    logic       byte_valid;
    logic [7:0] byte_data;

    hs4_byte_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .cmd_req   (cmd_req),
        .cmd_data  (cmd_data),
        .cmd_ack   (cmd_ack),
        .byte_valid(byte_valid),
        .byte_data (byte_data)
    );

    state_e               state_q, state_d;
    logic                 reg_req_q, reg_req_d;
    logic                 reg_we_q, reg_we_d;
    logic [15:0]          reg_addr_q, reg_addr_d;
    logic [15:0]          reg_wdata_q, reg_wdata_d;
    logic                 rsp_req_q, rsp_req_d;
    logic [7:0]           rsp_data_q, rsp_data_d;
    logic [7:0]           rsp_lo_q, rsp_lo_d;
    logic                 rsp_left_q, rsp_left_d;
    logic [RxCntW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [BusCntW-1:0]   bus_cnt_q, bus_cnt_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic [1:0]           err_inc;
    logic [8:0]           err_sum;
    logic                 in_frame;

    always_comb begin
        state_d     = state_q;
        reg_req_d   = reg_req_q;
        reg_we_d    = reg_we_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        rsp_req_d   = rsp_req_q;
        rsp_data_d  = rsp_data_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_left_d  = rsp_left_q;
        rx_cnt_d    = '0;
        bus_cnt_d   = '0;
        err_inc     = 2'd0;
        in_frame    = state_q inside {StAddrH, StAddrL, StDataH, StDataL};

        if (in_frame && !byte_valid) rx_cnt_d = rx_cnt_q + 1'b1;

        case (state_q)
            StIdle: if (byte_valid) begin
                if (byte_data == OP_RD || byte_data == OP_WR) begin
                    reg_we_d = (byte_data == OP_WR);
                    state_d  = StAddrH;
                end else begin
                    rsp_data_d = RSP_NAK;
                    rsp_left_d = 1'b0;
                    err_inc    = 2'd1;
                    state_d    = StRspLoad;
                end
            end
            StAddrH: if (byte_valid) begin
                reg_addr_d[15:8] = byte_data;
                state_d          = StAddrL;
            end
            StAddrL: if (byte_valid) begin
                reg_addr_d[7:0] = byte_data;
                if (reg_we_q) begin
                    state_d = StDataH;
                end else begin
                    state_d   = StBus;
                    reg_req_d = 1'b1;
                end
            end
            StDataH: if (byte_valid) begin
                reg_wdata_d[15:8] = byte_data;
                state_d           = StDataL;
            end
            StDataL: if (byte_valid) begin
                reg_wdata_d[7:0] = byte_data;
                state_d          = StBus;
                reg_req_d        = 1'b1;
            end
            StBus: begin
                bus_cnt_d = bus_cnt_q + 1'b1;
                // An ack coinciding with the timeout cycle is honoured.
                if (reg_ack) begin
                    reg_req_d = 1'b0;
                    state_d   = StRspLoad;
                    if (reg_we_q) begin
                        rsp_data_d = RSP_ACK;
                        rsp_left_d = 1'(RSP_LEN_WR - 1);
                    end else begin
                        rsp_data_d = reg_rdata[15:8];
                        rsp_lo_d   = reg_rdata[7:0];
                        rsp_left_d = 1'(RSP_LEN_RD - 1);
                    end
                end else if (bus_cnt_q == BusCntW'(P_BUS_TIMEOUT - 1)) begin
                    reg_req_d  = 1'b0;
                    rsp_data_d = RSP_NAK;
                    rsp_left_d = 1'b0;
                    err_inc    = 2'd1;
                    state_d    = StRspLoad;
                end
            end
            StRspLoad: begin
                rsp_req_d = 1'b1;
                state_d   = StRspWait;
            end
            StRspWait: if (rsp_ack) begin
                rsp_req_d = 1'b0;
                if (rsp_left_q) begin
                    rsp_left_d = 1'b0;
                    rsp_data_d = rsp_lo_q;
                    state_d    = StRspLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (in_frame && !byte_valid && rx_cnt_q == RxCntW'(P_RX_TIMEOUT - 1)) begin
            state_d = StIdle;
            err_inc = 2'd1;
        end

        // Bytes arriving while busy are acked by the receiver but dropped here.
        if (byte_valid && state_q inside {StBus, StRspLoad, StRspWait}) begin
            err_inc = err_inc + 2'd1;
        end

        err_sum   = {1'b0, err_cnt_q} + {7'd0, err_inc};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= 16'h0000;
            reg_wdata_q <= 16'h0000;
            rsp_req_q   <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_lo_q    <= 8'h00;
            rsp_left_q  <= 1'b0;
            rx_cnt_q    <= '0;
            bus_cnt_q   <= '0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            reg_req_q   <= reg_req_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            rsp_req_q   <= rsp_req_d;
            rsp_data_q  <= rsp_data_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_left_q  <= rsp_left_d;
            rx_cnt_q    <= rx_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rsp_req   = rsp_req_q;
    assign rsp_data  = rsp_data_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_req   = reg_req_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ft232r_reg_ctrl.sv
// Bench for ft232r_reg_ctrl: adapter, register-bus and rsp models with a response scoreboard.
module tb_ft232r_reg_ctrl;
    import ft232r_reg_pkg::*;

    localparam int unsigned RxTo  = 100;
    localparam int unsigned BusTo = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_req, cmd_ack;
    logic [7:0]  cmd_data;
    logic        rsp_req, rsp_ack;
    logic [7:0]  rsp_data;
    logic [15:0] reg_addr, reg_wdata, reg_rdata;
    logic        reg_we, reg_req, reg_ack;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    ft232r_reg_ctrl #(
        .P_CLK_FREQ_HZ(125_000_000),
        .P_RX_TIMEOUT (RxTo),
        .P_BUS_TIMEOUT(BusTo)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_req  (cmd_req),
        .cmd_ack  (cmd_ack),
        .cmd_data (cmd_data),
        .rsp_req  (rsp_req),
        .rsp_ack  (rsp_ack),
        .rsp_data (rsp_data),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_req  (reg_req),
        .reg_ack  (reg_ack),
        .reg_rdata(reg_rdata),
        .err_cnt  (err_cnt)
    );

    typedef struct {
        logic [7:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_on;  // reg_req cycle on which reg_ack is given; 0 = never
        bit          extra;   // send a stray byte while the frame is being serviced
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    int          rsp_count = 0;
    bit          rsp_busy  = 1'b0;
    int          ack_on    = 0;
    logic [15:0] rd_val    = 16'h0000;
    logic [15:0] exp_addr  = 16'h0000;
    logic [15:0] exp_wdata = 16'h0000;
    logic        exp_we    = 1'b0;
    int          req_cycles = 0;
    int          last_len   = 0;
    int          bus_done   = 0;
    int          err_exp    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        cmd_data = b;
        cmd_req  = 1'b1;
        n = 0;
        while (!cmd_ack && n < 50) begin @(negedge clk); n++; end
        check("cmd_ack_rise", cmd_ack, 1'b1);
        cmd_req = 1'b0;
        n = 0;
        while (cmd_ack && n < 50) begin @(negedge clk); n++; end
        check("cmd_ack_fall", cmd_ack, 1'b0);
    endtask

    // rsp side of the adapter: scores each rsp_req rise, then acks after a short delay
    initial begin : rsp_model
        logic       prev_req;
        logic [7:0] prev_data, got;
        prev_req  = 1'b0;
        prev_data = 8'h00;
        rsp_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req  = 1'b0;
                prev_data = 8'h00;
                rsp_ack   = 1'b0;
                rsp_busy  = 1'b0;
            end else if (rsp_req && !prev_req) begin
                rsp_busy = 1'b1;
                rsp_count++;
                got = rsp_data;
                check("rsp_data_setup", got, prev_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: actual 0x%0h required none", got);
                end else begin
                    check("rsp_byte", got, exp_q.pop_front());
                end
                repeat (2) @(negedge clk);
                rsp_ack = 1'b1;
                @(negedge clk);
                rsp_ack = 1'b0;
                check("rsp_req_clear", rsp_req, 1'b0);
                prev_req  = rsp_req;
                prev_data = rsp_data;
                rsp_busy  = 1'b0;
            end else begin
                prev_req  = rsp_req;
                prev_data = rsp_data;
            end
        end
    end

    // Register bus slave: checks the request fields and acks on the programmed cycle
    initial begin : bus_model
        reg_ack   = 1'b0;
        reg_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            reg_ack = 1'b0;
            if (reg_req) begin
                req_cycles++;
                if (req_cycles == 1 || req_cycles == ack_on) begin
                    check("reg_addr", reg_addr, exp_addr);
                    check("reg_we", reg_we, exp_we);
                    if (exp_we) check("reg_wdata", reg_wdata, exp_wdata);
                end
                if (req_cycles == ack_on) begin
                    reg_ack   = 1'b1;
                    reg_rdata = rd_val;
                end
            end else if (req_cycles != 0) begin
                last_len   = req_cycles;
                req_cycles = 0;
                bus_done++;
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int         n, n_exp, len_exp, c0_rsp, c0_bus, n_bytes;
        bit         timed_out;
        logic [7:0] fb[5];
        timed_out = (v.ack_on == 0) || (v.ack_on > int'(BusTo));
        exp_addr  = v.addr;
        exp_we    = (v.op == OP_WR);
        exp_wdata = v.wdata;
        rd_val    = v.rdata;
        ack_on    = v.ack_on;
        if (timed_out) begin
            exp_q.push_back(RSP_NAK);
            err_exp++;
            n_exp   = 1;
            len_exp = BusTo;
        end else if (exp_we) begin
            exp_q.push_back(RSP_ACK);
            n_exp   = 1;
            len_exp = v.ack_on;
        end else begin
            exp_q.push_back(v.rdata[15:8]);
            exp_q.push_back(v.rdata[7:0]);
            n_exp   = 2;
            len_exp = v.ack_on;
        end
        if (v.extra) err_exp++;
        c0_rsp  = rsp_count;
        c0_bus  = bus_done;
        fb      = '{v.op, v.addr[15:8], v.addr[7:0], v.wdata[15:8], v.wdata[7:0]};
        n_bytes = exp_we ? FRAME_LEN_WR : FRAME_LEN_RD;
        for (int i = 0; i < n_bytes; i++) send_byte(fb[i]);
        if (v.extra) send_byte(8'h99);
        n = 0;
        while ((bus_done == c0_bus || exp_q.size() != 0 || rsp_busy || rsp_req) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("frame_done", n < 500, 1'b1);
        check("reg_req_cycles", last_len, len_exp);
        check("rsp_byte_count", rsp_count - c0_rsp, n_exp);
        check("err_cnt", err_cnt, err_exp);
    endtask

    initial begin : main
        vec_t vecs[8];
        vec_t rd_after;
        int   n, c0, c0b;

        rst      = 1'b1;
        cmd_req  = 1'b0;
        cmd_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cmd_ack", cmd_ack, 1'b0);
        check("rst_rsp_req", rsp_req, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_reg_req", reg_req, 1'b0);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_reg_addr", reg_addr, 16'h0000);
        check("rst_reg_wdata", reg_wdata, 16'h0000);
        check("rst_err_cnt", err_cnt, 8'h00);
        rst = 1'b0;

        vecs[0] = '{OP_RD, 16'h1234, 16'h0000, 16'hBEEF, 3,  1'b0};
        vecs[1] = '{OP_WR, 16'h0010, 16'hCAFE, 16'h0000, 1,  1'b0};
        vecs[2] = '{OP_RD, 16'h00FF, 16'h0000, 16'h1111, 0,  1'b0};
        vecs[3] = '{OP_RD, 16'hA5A5, 16'h0000, 16'h1357, 16, 1'b0};
        vecs[4] = '{OP_WR, 16'hFFFF, 16'h0000, 16'h0000, 16, 1'b0};
        vecs[5] = '{OP_WR, 16'h8001, 16'h55AA, 16'h0000, 0,  1'b0};
        vecs[6] = '{OP_RD, 16'h0000, 16'h0000, 16'h0000, 2,  1'b0};
        vecs[7] = '{OP_RD, 16'h4242, 16'h0000, 16'hDEAD, 10, 1'b1};
        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Unknown opcode
        exp_q.push_back(RSP_NAK);
        err_exp++;
        c0 = rsp_count;
        send_byte(8'h41);
        n = 0;
        while ((exp_q.size() != 0 || rsp_busy || rsp_count == c0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("badop_rsp_count", rsp_count - c0, 1);
        check("badop_err_cnt", err_cnt, err_exp);
        rd_after = '{OP_RD, 16'h7E01, 16'h0000, 16'hC3A5, 1, 1'b0};
        run_frame(rd_after);

        // Inter-byte stall inside a frame
        c0  = rsp_count;
        c0b = bus_done;
        err_exp++;
        send_byte(OP_WR);
        send_byte(8'h00);
        repeat (RxTo + 50) @(negedge clk);
        check("rxto_no_rsp", rsp_count - c0, 0);
        check("rxto_no_bus", bus_done - c0b, 0);
        check("rxto_err_cnt", err_cnt, err_exp);
        rd_after = '{OP_RD, 16'h0001, 16'h0000, 16'h2468, 4, 1'b0};
        run_frame(rd_after);

        // Reset between the two bytes of a read response, with a cmd byte pending
        exp_addr = 16'h0BAD;
        exp_we   = 1'b0;
        rd_val   = 16'h7788;
        ack_on   = 2;
        exp_q.push_back(8'h77);
        c0 = rsp_count;
        send_byte(OP_RD);
        send_byte(8'h0B);
        send_byte(8'hAD);
        n = 0;
        while (rsp_count == c0 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (rsp_req && n < 50) begin @(negedge clk); n++; end
        check("rst_mid_first_done", rsp_req, 1'b0);
        rst      = 1'b1;
        cmd_data = 8'h5A;
        cmd_req  = 1'b1;
        @(negedge clk);
        check("rst_mid_rsp_req", rsp_req, 1'b0);
        check("rst_mid_cmd_ack", cmd_ack, 1'b0);
        check("rst_mid_err_cnt", err_cnt, 8'h00);
        check("rst_mid_reg_req", reg_req, 1'b0);
        cmd_req = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        err_exp = 0;
        repeat (60) @(negedge clk);
        check("rst_mid_no_more_rsp", rsp_count - c0, 1);
        check("rst_mid_queue_empty", exp_q.size(), 0);
        check("rst_mid_rsp_data", rsp_data, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400_000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
